// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: multi-cycle command sequencer for a single 32-bit function register.
// Runs byte-stream assembly (LOADB), counted INC/DEC, and decrement-to-zero (DRAIN)
// by driving the register's E/FunSel/I pins and watching its Q output.
// Optional feature macro: REGSEQ_SIGNEXT_EN adds the SEXT state, which sign-extends
// the low half of an assembled LOADB value when CmdCount[2] is set.
module reg_op_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdOp,
  input  logic [7:0]  CmdCount,
  input  logic        ByteValid,
  output logic        ByteReady,
  input  logic [7:0]  ByteIn,
  input  logic [31:0] RegQ,
  output logic        RegE,
  output logic [2:0]  RegFunSel,
  output logic [31:0] RegI,
  output logic        Busy,
  output logic        Done
);

  localparam logic [1:0] OP_LOADB = 2'b00;
  localparam logic [1:0] OP_INC   = 2'b01;
  localparam logic [1:0] OP_DEC   = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_ZEXTB = 3'b100;
  localparam logic [2:0] FS_SHL8  = 3'b110;
`ifdef REGSEQ_SIGNEXT_EN
  localparam logic [2:0] FS_SEXTH = 3'b111;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE  = 3'd1,
    STEP  = 3'd2,
    DRAIN = 3'd3,
`ifdef REGSEQ_SIGNEXT_EN
    SEXT  = 3'd4,
`endif
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [1:0]  opReg;
  logic [7:0]  countReg;
  logic [1:0]  byteIdx;
  logic [1:0]  byteLast;
`ifdef REGSEQ_SIGNEXT_EN
  logic        sextReq;
`endif

  // State register; a low Reset abandons whatever command is in flight
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Command latch, byte index and remaining step count
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      opReg    <= OP_LOADB;
      countReg <= 8'd0;
      byteIdx  <= 2'd0;
      byteLast <= 2'd0;
`ifdef REGSEQ_SIGNEXT_EN
      sextReq  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (CmdValid) begin
            opReg    <= CmdOp;
            countReg <= CmdCount;
            byteIdx  <= 2'd0;
            byteLast <= CmdCount[1:0];
`ifdef REGSEQ_SIGNEXT_EN
            sextReq  <= CmdCount[2];
`endif
          end
        end
        BYTE: begin
          if (ByteValid) begin
            byteIdx <= byteIdx + 2'd1;
          end
        end
        STEP: begin
          countReg <= countReg - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and register-pin drive; DRAIN leaves on the step that reaches zero so Done lands in cycle V+1
  always_comb begin
    stateNext = state;
    CmdReady  = 1'b0;
    ByteReady = 1'b0;
    RegE      = 1'b0;
    RegFunSel = FS_DEC;
    RegI      = 32'd0;
    Busy      = (state != IDLE);
    Done      = 1'b0;
    case (state)
      IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) begin
          case (CmdOp)
            OP_LOADB: stateNext = BYTE;
            OP_INC,
            OP_DEC:   stateNext = (CmdCount == 8'd0) ? DONE : STEP;
            OP_DRAIN: stateNext = (RegQ == 32'd0) ? DONE : DRAIN;
          endcase
        end
      end
      BYTE: begin
        ByteReady = 1'b1;
        RegE      = ByteValid;
        RegI      = {24'd0, ByteIn};
        RegFunSel = (byteIdx == 2'd0) ? FS_ZEXTB : FS_SHL8;
        if (ByteValid && (byteIdx == byteLast)) begin
`ifdef REGSEQ_SIGNEXT_EN
          stateNext = sextReq ? SEXT : DONE;
`else
          stateNext = DONE;
`endif
        end
      end
      STEP: begin
        RegE      = 1'b1;
        RegFunSel = (opReg == OP_INC) ? FS_INC : FS_DEC;
        if (countReg <= 8'd1) begin
          stateNext = DONE;
        end
      end
      DRAIN: begin
        RegE      = (RegQ != 32'd0);
        RegFunSel = FS_DEC;
        if (RegQ <= 32'd1) begin
          stateNext = DONE;
        end
      end
`ifdef REGSEQ_SIGNEXT_EN
      SEXT: begin
        RegE      = 1'b1;
        RegFunSel = FS_SEXTH;
        RegI      = {16'd0, RegQ[15:0]};
        stateNext = DONE;
      end
`endif
      DONE: begin
        Done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
    if (!Reset) begin
      CmdReady  = 1'b0;
      ByteReady = 1'b0;
      RegE      = 1'b0;
      RegFunSel = FS_DEC;
      RegI      = 32'd0;
      Busy      = 1'b0;
      Done      = 1'b0;
    end
  end

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Multi-cycle operation sequencer for one 32-bit function register (FunSel encoding: 000 dec, 001 inc, 010 load, 011 clear, 100 zero-extend byte, 101 zero-extend half, 110 shift-left-8 with byte insert, 111 sign-extend half). It accepts one command at a time over a valid/ready handshake and drives the register's E/FunSel/I pins to perform byte-stream assembly, counted increment or decrement, and decrement-to-zero. It sits between a control unit or byte-serial bus and a single register instance, and observes the register's Q output.

## Interface
- No parameters; data width fixed at 32, byte width 8.
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- CmdValid  in  1  command offered
- CmdReady  out  1  sequencer idle, accepts command
- CmdOp  in  2  00 LOADB, 01 INC, 10 DEC, 11 DRAIN
- CmdCount  in  8  LOADB: [1:0]+1 = byte count (1..4), [2] = sign-extend request; INC/DEC: step count; DRAIN: ignored
- ByteValid  in  1  byte offered on ByteIn
- ByteReady  out  1  sequencer consumes a byte this cycle if ByteValid
- ByteIn  in  8  byte data, most significant byte first
- RegQ  in  32  current register value
- RegE  out  1  register enable
- RegFunSel  out  3  register function select
- RegI  out  32  register data input
- Busy  out  1  command in progress (state ≠ IDLE)
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, BYTE, STEP, DRAIN, SEXT, DONE.
- IDLE: CmdReady=1. On CmdValid&CmdReady latch op and count; LOADB → BYTE (byte index 0), INC/DEC with count 0 → DONE, INC/DEC otherwise → STEP, DRAIN → DRAIN.
- BYTE: ByteReady=1; RegE = ByteValid; RegI = {24'b0, ByteIn}; RegFunSel = 100 for the first byte, 110 for later bytes. Index advances only on accepted byte. After last byte accepted: → SEXT if sign-extend enabled and requested, else → DONE. ByteValid low stalls indefinitely, no register activity.
- STEP: RegE=1, RegFunSel 001 (INC) or 000 (DEC) every cycle; remaining count decrements per cycle; after the step with remaining=1 → DONE. Register wrap-around (FFFFFFFF+1, 0−1) is the register's behaviour, not checked.
- DRAIN: RegE = (RegQ≠0), RegFunSel 000; when RegQ==0 → DONE (zero on entry → DONE with no RegE pulse).
- SEXT: one cycle, RegE=1, RegFunSel 111, RegI = {16'b0, RegQ[15:0]} → DONE.
- DONE: Done=1 for exactly one cycle → IDLE.
- Defaults whenever not specified: RegE=0, RegFunSel=000, RegI=0, ByteReady=0, CmdReady=0.
- CmdValid while Busy is ignored (not latched).

## Timing
- Reset low at a rising edge: state → IDLE, counters cleared; any operation in progress abandoned with no Done. All outputs are combinational from state and forced to 0 while Reset is low; after reset release: CmdReady=1, all others 0.
- Accept at edge 0. INC/DEC N (N≥1): RegE high in cycles 1..N, Done in cycle N+1. Count 0: Done in cycle 1.
- LOADB k bytes with ByteValid held high: bytes consumed in cycles 1..k, Done cycle k+1 (k+2 with SEXT).
- DRAIN from value V: RegE high V cycles, Done in cycle V+1.
- Earliest next accept: cycle after Done.
- Register updates on the same edge a RegE cycle ends; RegQ reflects it next cycle.

## Configuration
- REGSEQ_SIGNEXT_EN defined: SEXT state present; LOADB with CmdCount[2]=1 appends the sign-extend cycle.
- Not defined: SEXT state absent; CmdCount[2] ignored; LOADB always goes BYTE → DONE.

## Test plan
- LOADB CmdCount=3, bytes 12,34,56,78 back-to-back → FunSel 100,110,110,110 on cycles 1–4, RegQ=12345678, Done cycle 5.
- LOADB CmdCount=1, bytes 80,01 with a 3-cycle ByteValid gap between them → no RegE during gap, RegQ=00008001; with REGSEQ_SIGNEXT_EN and CmdCount=5 → extra FunSel 111 cycle, RegQ=FFFF8001.
- INC CmdCount=5 from RegQ=FFFFFFFE → 5 RegE cycles with 001, RegQ=00000003, Done cycle 6; INC CmdCount=0 → Done cycle 1, no RegE.
- DRAIN from RegQ=00000004 → 4 RegE cycles with 000, RegQ=0, Done cycle 5; DRAIN from 0 → Done cycle 1, no RegE.
- Reset low during STEP of DEC 10 after 3 steps → no Done, state IDLE, CmdReady=1 one cycle after release, RegE stays 0.
- CmdValid held high throughout a DEC 2 → only one command accepted; second accept occurs in the cycle after Done.
